// File: rtl/mem_arb_pkg.sv
// Shared types for the BRAM data-port arbiter: owner FSM states, response tag, helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } owner_state_e;

    typedef struct packed {
        logic valid;
        logic id;
    } resp_tag_t;

    localparam int BCNT_WIDTH = 8;

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_resp_router.sv
// Remembers which requester issued the read accepted last cycle and steers the
// 1-cycle-latency memory response back to that requester only.
module mem_arb_resp_router
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read_accept_i,
    input  logic                    read_id_i,
    input  logic                    mem_valid_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_out_i,
    input  logic [ADDRESS_BITS-1:0] mem_address_out_i,
    output logic                    r0_valid_o,
    output logic [DATA_WIDTH-1:0]   r0_data_out_o,
    output logic [ADDRESS_BITS-1:0] r0_address_out_o,
    output logic                    r1_valid_o,
    output logic [DATA_WIDTH-1:0]   r1_data_out_o,
    output logic [ADDRESS_BITS-1:0] r1_address_out_o
);

    resp_tag_t tag_q, tag_d;

    // Tag describes only the previous cycle, so writes and idle cycles clear it.
    always_comb begin
        tag_d.valid = read_accept_i;
        tag_d.id    = read_id_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_q <= '0;
        else        tag_q <= tag_d;
    end

    assign r0_valid_o = mem_valid_i & tag_q.valid & ~tag_q.id;
    assign r1_valid_o = mem_valid_i & tag_q.valid &  tag_q.id;

    assign r0_data_out_o    = r0_valid_o ? mem_data_out_i    : '0;
    assign r0_address_out_o = r0_valid_o ? mem_address_out_i : '0;
    assign r1_data_out_o    = r1_valid_o ? mem_data_out_i    : '0;
    assign r1_address_out_o = r1_valid_o ? mem_address_out_i : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the BRAM data port between the
// core data path (r0) and the loader/debug master (r1).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int BURST_MAX    = 4,
    parameter int FIRST_PRIO   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      r0_read_i,
    input  logic                      r0_write_i,
    input  logic [DATA_WIDTH/8-1:0]   r0_byte_en_i,
    input  logic [ADDRESS_BITS-1:0]   r0_address_i,
    input  logic [DATA_WIDTH-1:0]     r0_data_in_i,
    output logic                      r0_ready_o,
    output logic                      r0_valid_o,
    output logic [DATA_WIDTH-1:0]     r0_data_out_o,
    output logic [ADDRESS_BITS-1:0]   r0_address_out_o,
    input  logic                      r1_read_i,
    input  logic                      r1_write_i,
    input  logic [DATA_WIDTH/8-1:0]   r1_byte_en_i,
    input  logic [ADDRESS_BITS-1:0]   r1_address_i,
    input  logic [DATA_WIDTH-1:0]     r1_data_in_i,
    output logic                      r1_ready_o,
    output logic                      r1_valid_o,
    output logic [DATA_WIDTH-1:0]     r1_data_out_o,
    output logic [ADDRESS_BITS-1:0]   r1_address_out_o,
    output logic                      mem_read_o,
    output logic                      mem_write_o,
    output logic [DATA_WIDTH/8-1:0]   mem_byte_en_o,
    output logic [ADDRESS_BITS-1:0]   mem_address_o,
    output logic [DATA_WIDTH-1:0]     mem_data_in_o,
    input  logic [DATA_WIDTH-1:0]     mem_data_out_i,
    input  logic [ADDRESS_BITS-1:0]   mem_address_out_i,
    input  logic                      mem_valid_i,
    input  logic                      mem_ready_i
);

    localparam logic [BCNT_WIDTH-1:0] BURST_LIM = BCNT_WIDTH'(BURST_MAX);
    localparam logic                  PRIO_RST  = 1'(FIRST_PRIO);

    owner_state_e          state_q, state_d;
    logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic                  prio_q, prio_d;

    logic pend0, pend1;
    logic owner, own_pend, oth_pend;
    logic grant_valid, grant_id;

    logic                    sel_read, sel_write;
    logic [DATA_WIDTH/8-1:0] sel_byte_en;
    logic [ADDRESS_BITS-1:0] sel_address;
    logic [DATA_WIDTH-1:0]   sel_data;

    assign pend0 = r0_read_i | r0_write_i;
    assign pend1 = r1_read_i | r1_write_i;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        prio_d      = prio_q;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        owner       = (state_q == ST_OWN1);
        own_pend    = owner ? pend1 : pend0;
        oth_pend    = owner ? pend0 : pend1;

        // Reset also gates the grant so mem_* stay quiet while rst_n is low.
        if (mem_ready_i && rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (pend0 || pend1) begin
                        grant_valid = 1'b1;
                        grant_id    = (pend0 && pend1) ? prio_q : pend1;
                        prio_d      = ~grant_id;
                        bcnt_d      = BCNT_WIDTH'(1);
                        state_d     = grant_id ? ST_OWN1 : ST_OWN0;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (own_pend && (!oth_pend || bcnt_q < BURST_LIM)) begin
                        grant_valid = 1'b1;
                        grant_id    = owner;
                        if (bcnt_q < BURST_LIM) bcnt_d = bcnt_q + 1'b1;
                    end else if (oth_pend) begin
                        grant_valid = 1'b1;
                        grant_id    = ~owner;
                        prio_d      = owner;
                        bcnt_d      = BCNT_WIDTH'(1);
                        state_d     = owner ? ST_OWN0 : ST_OWN1;
                    end else begin
                        prio_d  = ~owner;
                        bcnt_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            prio_q  <= PRIO_RST;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            prio_q  <= prio_d;
        end
    end

    assign sel_read    = grant_id ? r1_read_i    : r0_read_i;
    assign sel_write   = grant_id ? r1_write_i   : r0_write_i;
    assign sel_byte_en = grant_id ? r1_byte_en_i : r0_byte_en_i;
    assign sel_address = grant_id ? r1_address_i : r0_address_i;
    assign sel_data    = grant_id ? r1_data_in_i : r0_data_in_i;

    // Read wins when both strobes are high, so an illegal request never writes.
    assign mem_read_o    = grant_valid & sel_read;
    assign mem_write_o   = grant_valid & sel_write & ~sel_read;
    assign mem_byte_en_o = grant_valid ? sel_byte_en : '0;
    assign mem_address_o = grant_valid ? sel_address : '0;
    assign mem_data_in_o = grant_valid ? sel_data    : '0;

    assign r0_ready_o = grant_valid & ~grant_id;
    assign r1_ready_o = grant_valid &  grant_id;

    mem_arb_resp_router #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDRESS_BITS(ADDRESS_BITS)
    ) u_resp_router (
        .clk              (clk),
        .rst_n            (rst_n),
        .read_accept_i    (mem_read_o),
        .read_id_i        (grant_id),
        .mem_valid_i      (mem_valid_i),
        .mem_data_out_i   (mem_data_out_i),
        .mem_address_out_i(mem_address_out_i),
        .r0_valid_o       (r0_valid_o),
        .r0_data_out_o    (r0_data_out_o),
        .r0_address_out_o (r0_address_out_o),
        .r1_valid_o       (r1_valid_o),
        .r1_data_out_o    (r1_data_out_o),
        .r1_address_out_o (r1_address_out_o)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 1-cycle-latency behavioural BRAM.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          r0_read, r0_write, r1_read, r1_write;
    logic [3:0]    r0_byte_en, r1_byte_en;
    logic [AW-1:0] r0_address, r1_address;
    logic [DW-1:0] r0_data_in, r1_data_in;
    logic          r0_ready, r0_valid, r1_ready, r1_valid;
    logic [DW-1:0] r0_data_out, r1_data_out;
    logic [AW-1:0] r0_address_out, r1_address_out;
    logic          mem_read, mem_write;
    logic [3:0]    mem_byte_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out = '0;
    logic [AW-1:0] mem_address_out = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;

    mem_port_arbiter #(
        .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .BURST_MAX(4), .FIRST_PRIO(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_read_i(r0_read), .r0_write_i(r0_write), .r0_byte_en_i(r0_byte_en),
        .r0_address_i(r0_address), .r0_data_in_i(r0_data_in),
        .r0_ready_o(r0_ready), .r0_valid_o(r0_valid),
        .r0_data_out_o(r0_data_out), .r0_address_out_o(r0_address_out),
        .r1_read_i(r1_read), .r1_write_i(r1_write), .r1_byte_en_i(r1_byte_en),
        .r1_address_i(r1_address), .r1_data_in_i(r1_data_in),
        .r1_ready_o(r1_ready), .r1_valid_o(r1_valid),
        .r1_data_out_o(r1_data_out), .r1_address_out_o(r1_address_out),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_byte_en_o(mem_byte_en),
        .mem_address_o(mem_address), .mem_data_in_o(mem_data_in),
        .mem_data_out_i(mem_data_out), .mem_address_out_i(mem_address_out),
        .mem_valid_i(mem_valid), .mem_ready_i(mem_ready)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a >= 32'h100) ? {16'hC0DE, a[15:0]} : 32'h0;
    endfunction

    // Behavioural BRAM: initialised on the first edge, 1-cycle read latency.
    logic [31:0] mem_arr [512];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 512; i++) mem_arr[i] <= pat(32'(i * 4));
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) mem_arr[mem_address[10:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
        mem_valid       <= mem_read;
        mem_data_out    <= mem_arr[mem_address[10:2]];
        mem_address_out <= mem_address;
    end

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        mon_e;
    logic        mon_valid, mon_other;
    logic [31:0] mon_data, mon_addr;
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e     = sb.pop_front();
            mon_valid = mon_e.id ? r1_valid : r0_valid;
            mon_other = mon_e.id ? r0_valid : r1_valid;
            mon_data  = mon_e.id ? r1_data_out : r0_data_out;
            mon_addr  = mon_e.id ? r1_address_out : r0_address_out;
            n_compared++;
            if ({mon_valid, mon_other} !== 2'b10 || mon_data !== mon_e.data || mon_addr !== mon_e.addr) begin
                n_mismatched++;
                $display("FAIL resp_r%0d: valid=%b other_valid=%b data=%h addr=%h, want valid=1 other_valid=0 data=%h addr=%h",
                         mon_e.id, mon_valid, mon_other, mon_data, mon_addr, mon_e.data, mon_e.addr);
            end
        end else if (r0_valid || r1_valid) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL unexpected_valid: r0_valid=%b r1_valid=%b, want 0 0", r0_valid, r1_valid);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        r0_read = 0; r0_write = 0; r0_byte_en = '0; r0_address = '0; r0_data_in = '0;
        r1_read = 0; r1_write = 0; r1_byte_en = '0; r1_address = '0; r1_data_in = '0;
    endtask

    task automatic push_exp(input logic id, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.id = id; e.addr = addr; e.data = data; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        idle_inputs();
        mem_ready = 1;
        rst_n = 0;
        r0_read = 1;
        r0_address = 32'h100;
        repeat (3) tick();
        @(negedge clk);
        obs = {r0_ready, r1_ready, r0_valid, r1_valid, mem_read, mem_write};
        n_compared++;
        if (obs !== 6'b0) begin
            n_mismatched++;
            $display("FAIL reset_strobes: got %b, want 000000", obs);
        end
        n_compared++;
        if (mem_address !== '0 || r0_data_out !== '0 || r0_address_out !== '0) begin
            n_mismatched++;
            $display("FAIL reset_buses: mem_address=%h r0_data_out=%h r0_address_out=%h, want 0",
                     mem_address, r0_data_out, r0_address_out);
        end
        tick();
        idle_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_read;
        r0_read = 1;
        r0_address = 32'h100;
        @(negedge clk);
        n_compared++;
        if ({r0_ready, r1_ready, mem_read, mem_write} !== 4'b1010 || mem_address !== 32'h100) begin
            n_mismatched++;
            $display("FAIL single_accept: r0_ready=%b r1_ready=%b mem_read=%b mem_write=%b addr=%h, want 1 0 1 0 00000100",
                     r0_ready, r1_ready, mem_read, mem_write, mem_address);
        end
        push_exp(1'b0, 32'h100, pat(32'h100));
        tick();
        idle_inputs();
        @(negedge clk);
        n_compared++;
        if ({r0_valid, r1_valid} !== 2'b10) begin
            n_mismatched++;
            $display("FAIL single_valid: r0_valid=%b r1_valid=%b, want 1 0", r0_valid, r1_valid);
        end
        tick();
    endtask

    task automatic test_write_then_read;
        r1_write = 1;
        r1_address = 32'h40;
        r1_data_in = 32'hDEADBEEF;
        r1_byte_en = 4'b0011;
        @(negedge clk);
        n_compared++;
        if ({r1_ready, r0_ready, mem_write, mem_read} !== 4'b1010 || mem_byte_en !== 4'b0011 ||
            mem_data_in !== 32'hDEADBEEF || mem_address !== 32'h40) begin
            n_mismatched++;
            $display("FAIL write_accept: r1_ready=%b r0_ready=%b wr=%b rd=%b be=%b data=%h addr=%h, want 1 0 1 0 0011 deadbeef 00000040",
                     r1_ready, r0_ready, mem_write, mem_read, mem_byte_en, mem_data_in, mem_address);
        end
        tick();
        idle_inputs();
        r0_read = 1;
        r0_address = 32'h40;
        @(negedge clk);
        n_compared++;
        if ({r0_ready, r0_valid, r1_valid} !== 3'b100) begin
            n_mismatched++;
            $display("FAIL write_no_valid: r0_ready=%b r0_valid=%b r1_valid=%b, want 1 0 0", r0_ready, r0_valid, r1_valid);
        end
        push_exp(1'b0, 32'h40, 32'h0000BEEF);
        tick();
        idle_inputs();
        @(negedge clk);
        tick();
    endtask

    // Both requesters read continuously; bit c of stall drops mem_ready in cycle c.
    task automatic contend(input int n, input logic [31:0] stall, input string name);
        int j, n0, n1;
        logic g;
        logic [31:0] a;
        j = 0; n0 = 0; n1 = 0;
        for (int c = 0; c < n; c++) begin
            r0_read = 1;
            r1_read = 1;
            r0_address = 32'h100 + 32'(4 * n0);
            r1_address = 32'h200 + 32'(4 * n1);
            mem_ready = !stall[c];
            @(negedge clk);
            n_compared++;
            if (stall[c]) begin
                if ({r0_ready, r1_ready, mem_read} !== 3'b000) begin
                    n_mismatched++;
                    $display("FAIL %s_stall c%0d: r0_ready=%b r1_ready=%b mem_read=%b, want 0 0 0",
                             name, c, r0_ready, r1_ready, mem_read);
                end
            end else begin
                g = ((j / 4) % 2) == 1;
                a = g ? r1_address : r0_address;
                if ({r0_ready, r1_ready} !== {~g, g} || mem_address !== a) begin
                    n_mismatched++;
                    $display("FAIL %s_grant c%0d: r0_ready=%b r1_ready=%b addr=%h, want %b %b %h",
                             name, c, r0_ready, r1_ready, mem_address, ~g, g, a);
                end
                push_exp(g, a, pat(a));
                j++;
                if (g) n1++; else n0++;
            end
            tick();
        end
        idle_inputs();
        mem_ready = 1;
        tick();
        tick();
    endtask

    task automatic test_back_to_back;
        apply_reset();
        contend(12, 32'h0, "burst");
    endtask

    task automatic test_stall;
        apply_reset();
        contend(11, 32'b11100, "stall");
    endtask

    task automatic test_reset_mid_op;
        r0_read = 1;
        r0_address = 32'h104;
        @(negedge clk);
        n_compared++;
        if (r0_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL midreset_accept: r0_ready=%b, want 1", r0_ready);
        end
        tick();
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        n_compared++;
        if (r0_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midreset_drop: r0_valid=%b, want 0", r0_valid);
        end
        tick();
        rst_n = 1;
        r0_read = 1; r0_address = 32'h10C;
        r1_read = 1; r1_address = 32'h20C;
        @(negedge clk);
        n_compared++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            n_mismatched++;
            $display("FAIL midreset_first_prio: r0_ready=%b r1_ready=%b, want 1 0", r0_ready, r1_ready);
        end
        push_exp(1'b0, 32'h10C, pat(32'h10C));
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_illegal;
        r0_read = 1;
        r0_write = 1;
        r0_address = 32'h108;
        r0_data_in = 32'hFFFFFFFF;
        r0_byte_en = 4'hF;
        @(negedge clk);
        n_compared++;
        if ({r0_ready, mem_read, mem_write} !== 3'b110) begin
            n_mismatched++;
            $display("FAIL illegal_as_read: r0_ready=%b mem_read=%b mem_write=%b, want 1 1 0", r0_ready, mem_read, mem_write);
        end
        push_exp(1'b0, 32'h108, pat(32'h108));
        tick();
        r0_write = 0;
        @(negedge clk);
        n_compared++;
        if (r0_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL illegal_reread: r0_ready=%b, want 1", r0_ready);
        end
        push_exp(1'b0, 32'h108, pat(32'h108));
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        mem_ready = 1;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_back_to_back();
        test_stall();
        test_reset_mid_op();
        test_illegal();
        for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
